// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul host-side front end.
package matmul_pkg;

    typedef enum logic [2:0] {
        LOAD_X,
        LOAD_Y,
        START,
        WAIT,
        DRAIN
    } host_state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/matmul_stream_if.sv
// Host word streams: X/Y words in, Z words out, both valid/ready.
interface matmul_stream_if #(
    parameter int DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/matmul_out_fifo.sv
// Small skid FIFO between the Z BRAM read pipeline and the output stream.
module matmul_out_fifo
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(pop && count == '0));
            assert (!(push && !pop && count == CNT_W'(FIFO_DEPTH)));
        end
    end

endmodule

// File: rtl/matmul_host_if.sv
// Streams one X/Y job into the BRAMs, kicks the core, then streams Z back out.
module matmul_host_if
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int MATRIX_SIZE = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    matmul_stream_if.slave        stream,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic                  x_wr_en,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic                  y_wr_en,
    output logic                  start,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST  = CW'(MATRIX_SIZE - 1);
    localparam logic [CW-1:0] LIMIT = CW'(MATRIX_SIZE);

    if (MATRIX_SIZE > 2**ADDR_WIDTH) begin : g_size_check
        $error("MATRIX_SIZE does not fit in ADDR_WIDTH");
    end

    host_state_t             state;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           rd_cnt;
    logic [CW-1:0]           out_cnt;
    logic                    inflight;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic                    fifo_valid;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic                    handshake;
    logic                    pop;
    logic [2:0]              occupancy;
    logic                    rd_issue;

    assign handshake = stream.in_valid & stream.in_ready;
    assign pop       = fifo_valid & stream.out_ready;

    // Count the word already travelling through the BRAM so the FIFO can never be overrun.
    assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign rd_issue  = (state == DRAIN) && (rd_cnt < LIMIT) && (occupancy < 3'(FIFO_DEPTH));
    assign z_rd_addr = (state == DRAIN) ? rd_cnt[ADDR_WIDTH-1:0] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= LOAD_X;
            cnt             <= '0;
            rd_cnt          <= '0;
            out_cnt         <= '0;
            inflight        <= 1'b0;
            stream.in_ready <= 1'b0;
            busy            <= 1'b0;
            start           <= 1'b0;
            x_wr_en         <= 1'b0;
            x_wr_addr       <= '0;
            x_din           <= '0;
            y_wr_en         <= 1'b0;
            y_wr_addr       <= '0;
            y_din           <= '0;
        end else begin
            x_wr_en  <= 1'b0;
            y_wr_en  <= 1'b0;
            start    <= 1'b0;
            inflight <= rd_issue;
            if (rd_issue) rd_cnt <= rd_cnt + 1'b1;

            case (state)
                LOAD_X: begin
                    stream.in_ready <= 1'b1;
                    if (handshake) begin
                        x_wr_en   <= 1'b1;
                        x_wr_addr <= cnt[ADDR_WIDTH-1:0];
                        x_din     <= stream.in_data;
                        busy      <= 1'b1;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= LOAD_Y;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_Y: begin
                    if (handshake) begin
                        y_wr_en   <= 1'b1;
                        y_wr_addr <= cnt[ADDR_WIDTH-1:0];
                        y_din     <= stream.in_data;
                        if (cnt == LAST) begin
                            cnt             <= '0;
                            stream.in_ready <= 1'b0;
                            state           <= START;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                // The last Y write lands on the edge that raises start.
                START: begin
                    start <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        if (out_cnt == LAST) begin
                            cnt             <= '0;
                            busy            <= 1'b0;
                            stream.in_ready <= 1'b1;
                            state           <= LOAD_X;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD_X;
            endcase
        end
    end

    matmul_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data (z_dout),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign stream.out_data  = fifo_head;
    assign stream.out_valid = fifo_valid;

endmodule
